// File: rtl/ram_loader_pkg.sv
// Shared types for the serial boot loader.
// Loader and UART receiver state encodings.
package loader_pkg;

  typedef enum logic [1:0] {
    S_LEN,
    S_DATA,
    S_RUN
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/ram_loader_if.sv
// Received-byte stream from the UART receiver to the loader.
// The master side produces single-cycle strobes.
interface ram_loader_if #(
  parameter int DATA_W = 8
);
  logic              byte_valid;
  logic [DATA_W-1:0] byte_data;
  logic              frame_err_pulse;

  modport master (
    output byte_valid,
    output byte_data,
    output frame_err_pulse
  );

  modport slave (
    input byte_valid,
    input byte_data,
    input frame_err_pulse
  );
endinterface

// File: rtl/ram_loader_uart_rx.sv
// 8N1 UART receiver, LSB first, with rx synchroniser.
// Emits a byte strobe or a framing-error strobe per frame.
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx,
  ram_loader_if.master  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);

  rx_state_t         st_q, st_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    data_d  = data_q;
    ferr_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        // after a low stop bit this waits for rx to rise first
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_W-1:1]};
          if (bit_q == LAST) st_d = RX_STOP;
          else bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          st_d  = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.byte_valid      = valid_q;
  assign bus.byte_data       = data_q;
  assign bus.frame_err_pulse = ferr_q;

endmodule

// File: rtl/ram_loader.sv
// Serial boot loader: fills RAM from UART, then hands the
// RAM port to the processor and releases its reset.
module ram_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx,
  input  logic [ADDR_W-1:0] proc_ram_addr,
  input  logic              proc_ram_write,
  input  logic [DATA_W-1:0] proc_ram_data_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_data_write,
  output logic              cpu_reset_n,
  output logic              loading,
  output logic              frame_err
);

  localparam int CNT_W = DATA_W + 1;

  ram_loader_if #(.DATA_W(DATA_W)) rx_bus ();

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx (
    .clk     (clk),
    .reset_n (reset_n),
    .rx      (rx),
    .bus     (rx_bus)
  );

  loader_state_t     st_q, st_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              loading_q, loading_d;
  logic              ferr_q, ferr_d;
  logic              bv, fe;
  logic [DATA_W-1:0] bd;

  assign bv = rx_bus.byte_valid;
  assign bd = rx_bus.byte_data;
  assign fe = rx_bus.frame_err_pulse;

  always_comb begin
    st_d        = st_q;
    ptr_d       = ptr_q;
    left_d      = left_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wd_d        = wd_q;
    cpu_rst_n_d = cpu_rst_n_q;
    loading_d   = loading_q;
    ferr_d      = ferr_q;
    unique case (st_q)
      S_LEN: begin
        if (fe) begin
          ferr_d = 1'b1;
          ptr_d  = '0;
        end else if (bv) begin
          // a zero length byte stands for a full 256-byte image
          left_d = (bd == '0) ? CNT_W'(1 << DATA_W)
                              : {1'b0, bd};
          ptr_d  = '0;
          st_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (fe) begin
          ferr_d = 1'b1;
          ptr_d  = '0;
          st_d   = S_LEN;
        end else if (bv) begin
          we_d   = 1'b1;
          addr_d = ptr_q;
          wd_d   = bd;
          ptr_d  = ptr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == CNT_W'(1)) st_d = S_RUN;
        end
      end
      S_RUN: begin
        cpu_rst_n_d = 1'b1;
        loading_d   = 1'b0;
      end
      default: st_d = S_LEN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= S_LEN;
      ptr_q       <= '0;
      left_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wd_q        <= '0;
      cpu_rst_n_q <= 1'b0;
      loading_q   <= 1'b1;
      ferr_q      <= 1'b0;
    end else begin
      st_q        <= st_d;
      ptr_q       <= ptr_d;
      left_q      <= left_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      loading_q   <= loading_d;
      ferr_q      <= ferr_d;
    end
  end

  assign ram_addr       = loading_q ? addr_q : proc_ram_addr;
  assign ram_write      = loading_q ? we_q : proc_ram_write;
  assign ram_data_write = loading_q ? wd_q
                                    : proc_ram_data_write;
  assign cpu_reset_n    = cpu_rst_n_q;
  assign loading        = loading_q;
  assign frame_err      = ferr_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a falling-edge RAM model.
// Bit time is 8 clocks.
module tb_ram_loader;
  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] proc_ram_addr = 8'h00;
  logic       proc_ram_write = 1'b0;
  logic [7:0] proc_ram_data_write = 8'h00;
  logic [7:0] ram_addr;
  logic       ram_write;
  logic [7:0] ram_data_write;
  logic       cpu_reset_n;
  logic       loading;
  logic       frame_err;

  ram_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (8),
    .DATA_W       (8)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rx                  (rx),
    .proc_ram_addr       (proc_ram_addr),
    .proc_ram_write      (proc_ram_write),
    .proc_ram_data_write (proc_ram_data_write),
    .ram_addr            (ram_addr),
    .ram_write           (ram_write),
    .ram_data_write      (ram_data_write),
    .cpu_reset_n         (cpu_reset_n),
    .loading             (loading),
    .frame_err           (frame_err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int cyc = 0;
  int nwr = 0;
  int all_wr = 0;
  int last_wr_cyc = 0;
  int last_wr_addr = 0;
  int rel_cyc = 0;
  logic prev_cpu = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (ram_write === 1'b1) begin
      all_wr = all_wr + 1;
      mem[ram_addr] = ram_data_write;
      if (loading) begin
        nwr = nwr + 1;
        last_wr_cyc = cyc;
        last_wr_addr = int'(ram_addr);
      end
    end
    if (cpu_reset_n && !prev_cpu) rel_cyc = cyc;
    prev_cpu = cpu_reset_n;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
    if (!stop) tick(2 * CPB);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(3);
  endtask

  int snap;
  int bad;

  initial begin
    do_reset();
    chk("rst_cpu", cpu_reset_n, 0);
    chk("rst_loading", loading, 1);
    chk("rst_we", ram_write, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wd", ram_data_write, 0);
    proc_ram_addr = 8'h55;
    proc_ram_write = 1'b1;
    #1;
    chk("rst_proc_blocked", ram_write, 0);
    proc_ram_write = 1'b0;

    // basic 3-byte load
    snap = nwr;
    send_byte(8'h03, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h0F, 1'b1);
    tick(20);
    chk("load_nwr", nwr - snap, 3);
    chk("load_m0", mem[0], 8'hA5);
    chk("load_m1", mem[1], 8'h3C);
    chk("load_m2", mem[2], 8'h0F);
    chk("load_cpu", cpu_reset_n, 1);
    chk("load_loading", loading, 0);
    chk("load_rel_gap", rel_cyc - last_wr_cyc, 1);

    // pass-through after load
    proc_ram_addr = 8'h42;
    proc_ram_write = 1'b1;
    proc_ram_data_write = 8'h99;
    #1;
    chk("pass_addr", ram_addr, 8'h42);
    chk("pass_we", ram_write, 1);
    chk("pass_wd", ram_data_write, 8'h99);
    tick(1);
    proc_ram_write = 1'b0;
    tick(1);
    snap = all_wr;
    send_byte(8'h55, 1'b1);
    send_byte(8'h01, 1'b1);
    tick(20);
    chk("run_ignore_rx", all_wr - snap, 0);
    chk("run_cpu", cpu_reset_n, 1);

    // framing error aborts the load
    do_reset();
    snap = nwr;
    send_byte(8'h02, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    tick(10);
    chk("fe_flag", frame_err, 1);
    chk("fe_nwr", nwr - snap, 1);
    chk("fe_m0", mem[0], 8'h11);
    chk("fe_cpu", cpu_reset_n, 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h77, 1'b1);
    tick(20);
    chk("fe_reload_m0", mem[0], 8'h77);
    chk("fe_reload_cpu", cpu_reset_n, 1);
    chk("fe_sticky", frame_err, 1);

    // 256-byte image, back to back
    do_reset();
    chk("rst_ferr_clear", frame_err, 0);
    snap = nwr;
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 200) chk("big_hold_cpu", cpu_reset_n, 0);
    end
    tick(20);
    chk("big_nwr", nwr - snap, 256);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== 8'(i)) bad++;
    chk("big_mem", bad, 0);
    chk("big_last_addr", last_wr_addr, 8'hFF);
    chk("big_rel_gap", rel_cyc - last_wr_cyc, 1);
    chk("big_cpu", cpu_reset_n, 1);

    // reset in the middle of a data byte
    do_reset();
    snap = nwr;
    send_byte(8'h03, 1'b1);
    send_byte(8'hAA, 1'b1);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(CPB);
    end
    reset_n = 1'b0;
    #1;
    chk("mid_we", ram_write, 0);
    chk("mid_cpu", cpu_reset_n, 0);
    chk("mid_loading", loading, 1);
    chk("mid_nwr", nwr - snap, 1);
    chk("mid_m0", mem[0], 8'hAA);
    rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(20);
    send_byte(8'h02, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h6B, 1'b1);
    tick(20);
    chk("mid_reload_m0", mem[0], 8'h5A);
    chk("mid_reload_m1", mem[1], 8'h6B);
    chk("mid_reload_cpu", cpu_reset_n, 1);

    // short low glitch is not a start bit
    do_reset();
    snap = nwr;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(12 * CPB);
    chk("glitch_nwr", nwr - snap, 0);
    chk("glitch_ferr", frame_err, 0);
    chk("glitch_cpu", cpu_reset_n, 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h3E, 1'b1);
    tick(20);
    chk("glitch_m0", mem[0], 8'h3E);
    chk("glitch_rel", cpu_reset_n, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
